// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - WIDTH-bit pipelined ALU: single-cycle logic/arith ops plus iterative MUL/DIVU/REMU behind valid/ready.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU = 4'd10, OP_PASS = 4'd11;
    localparam logic [3:0] OP_NOTA = 4'd12, OP_MUL  = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op;
    logic             dz_pend;
    // MUL: acc=partial product, x=multiplicand, y=multiplier.
    // DIV: acc=partial remainder, x=divisor, y=dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] acc, x, y;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH-1:0] mul_acc_n, div_acc_n, div_quo_n, fin_res;
    logic [WIDTH:0]   div_r;
    logic             div_ge, take;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign take     = in_valid && in_ready;

    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SLL:  alu_res = A << B[SHW-1:0];
            OP_SRL:  alu_res = A >> B[SHW-1:0];
            OP_SRA:  alu_res = $signed(A) >>> B[SHW-1:0];
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
            OP_PASS: alu_res = A;
            OP_NOTA: alu_res = ~A;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        mul_acc_n = acc + (y[0] ? x : '0);
        div_r     = {acc, y[WIDTH-1]};
        div_ge    = div_r >= {1'b0, x};
        div_acc_n = div_ge ? (div_r[WIDTH-1:0] - x) : div_r[WIDTH-1:0];
        div_quo_n = {y[WIDTH-2:0], div_ge};
        if (op == OP_MUL)       fin_res = mul_acc_n;
        else if (op == OP_DIVU) fin_res = div_quo_n;
        else                    fin_res = div_acc_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= OP_ADD;
            dz_pend   <= 1'b0;
            acc       <= '0;
            x         <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else if (take) begin
            if (sel == OP_MUL || sel == OP_DIVU || sel == OP_REMU) begin
                state     <= BUSY;
                out_valid <= 1'b0;
                cnt       <= '0;
                op        <= sel;
                acc       <= '0;
                x         <= (sel == OP_MUL) ? A : B;
                y         <= (sel == OP_MUL) ? B : A;
                dz_pend   <= (sel != OP_MUL) && (B == '0);
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                carry     <= alu_c;
                ovf       <= alu_v;
                dz        <= 1'b0;
            end
        end else begin
            case (state)
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (op == OP_MUL) begin
                        acc <= mul_acc_n;
                        x   <= x << 1;
                        y   <= y >> 1;
                    end else begin
                        acc <= div_acc_n;
                        y   <= div_quo_n;
                    end
                    // Final step registers its own combinational result directly.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= fin_res;
                        zero      <= (fin_res == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        dz        <= dz_pend;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed table-driven bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        zero, carry, ovf, dz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .ovf(ovf), .dz(dz)
    );

    // flags packed as {zero, carry, ovf, dz}
    typedef struct {
        logic [3:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int guard, lat, busy_low;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        sel = v.sel; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom);
        lat = 1; busy_low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), (v.sel >= 4'd13) ? 32'd17 : 32'd1);
        check({tag, " busy"}, 32'(busy_low), (v.sel >= 4'd13) ? 32'd16 : 32'd0);
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " flags"}, 32'({zero, carry, ovf, dz}), 32'(v.flags));
        @(posedge clk); #1;
        check({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int exp1[5] = '{13, 7, 2, 11, 9};

        vecs[0]  = '{4'd0,  16'd10,     16'd3,      16'd13,     4'b0000};
        vecs[1]  = '{4'd1,  16'd10,     16'd3,      16'd7,      4'b0000};
        vecs[2]  = '{4'd2,  16'd10,     16'd3,      16'd2,      4'b0000};
        vecs[3]  = '{4'd3,  16'd10,     16'd3,      16'd11,     4'b0000};
        vecs[4]  = '{4'd4,  16'd10,     16'd3,      16'd9,      4'b0000};
        vecs[5]  = '{4'd5,  16'd10,     16'd3,      16'hFFF4,   4'b0000};
        vecs[6]  = '{4'd6,  16'd10,     16'd3,      16'h0050,   4'b0000};
        vecs[7]  = '{4'd7,  16'h8000,   16'd4,      16'h0800,   4'b0000};
        vecs[8]  = '{4'd8,  16'h8000,   16'd4,      16'hF800,   4'b0000};
        vecs[9]  = '{4'd9,  16'hFFFF,   16'd3,      16'd1,      4'b0000};
        vecs[10] = '{4'd10, 16'hFFFF,   16'd3,      16'd0,      4'b1000};
        vecs[11] = '{4'd11, 16'd10,     16'd3,      16'd10,     4'b0000};
        vecs[12] = '{4'd12, 16'd10,     16'd3,      16'hFFF5,   4'b0000};
        vecs[13] = '{4'd13, 16'd10,     16'd3,      16'd30,     4'b0000};
        vecs[14] = '{4'd14, 16'd10,     16'd3,      16'd3,      4'b0000};
        vecs[15] = '{4'd15, 16'd10,     16'd3,      16'd1,      4'b0000};
        vecs[16] = '{4'd0,  16'h7FFF,   16'd1,      16'h8000,   4'b0010};
        vecs[17] = '{4'd1,  16'd3,      16'd10,     16'hFFF9,   4'b0100};
        vecs[18] = '{4'd0,  16'hFFFF,   16'd1,      16'h0000,   4'b1100};
        vecs[19] = '{4'd1,  16'h8000,   16'd1,      16'h7FFF,   4'b0010};
        vecs[20] = '{4'd14, 16'd10,     16'd0,      16'hFFFF,   4'b0001};
        vecs[21] = '{4'd15, 16'd10,     16'd0,      16'd10,     4'b0001};
        vecs[22] = '{4'd15, 16'd0,      16'd0,      16'd0,      4'b1001};
        vecs[23] = '{4'd13, 16'h1234,   16'h0100,   16'h3400,   4'b0000};
        vecs[24] = '{4'd13, 16'hFFFF,   16'hFFFF,   16'h0001,   4'b0000};
        vecs[25] = '{4'd6,  16'd1,      16'h001F,   16'h8000,   4'b0000};
        vecs[26] = '{4'd14, 16'hFFFF,   16'h0010,   16'h0FFF,   4'b0000};
        vecs[27] = '{4'd15, 16'hFFFF,   16'h0010,   16'h000F,   4'b0000};

        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'({zero, carry, ovf, dz}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 28; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // back-to-back single-cycle ops, one result per clock
        a = 16'd10; b = 16'd3; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = 4'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("b2b%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("b2b%0d result", i), 32'(result), 32'(exp1[i]));
            check($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b drained", 32'(out_valid), 32'd0);

        // output stall holds result and blocks input
        out_ready = 1'b0; sel = 4'd0; a = 16'd10; b = 16'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'd99;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d result", i), 32'(result), 32'd13);
            check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("stall release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("stall one transfer", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("stall stays idle", 32'(out_valid), 32'd0);

        // async reset during MUL iteration
        sel = 4'd13; a = 16'd10; b = 16'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("mid-busy in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst result", 32'(result), 32'd0);
        check("mid rst flags", 32'({zero, carry, ovf, dz}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post rst in_ready", 32'(in_ready), 32'd1);
        run_op(vecs[0], "post_rst_add");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
